// File: rtl/icache_mem_latency_shim.sv
// Fixed-latency, in-order instruction fetch shim between the icache and a combinational memory model.
// Optional statistics counters are built only when SHIM_STATS_EN is defined.
module icache_mem_latency_shim #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int IDX_W   = 12,
  parameter int VPN_W   = 28,
  parameter int LINE_W  = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IDX_W-1:0]       req_idx_i,
  input  logic [VPN_W-1:0]       req_vpn_i,
  input  logic                   req_kill_i,
  output logic [IDX_W+VPN_W-1:0] mem_addr_o,
  input  logic [LINE_W-1:0]      mem_line_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [LINE_W-1:0]      resp_line_o,
  output logic [IDX_W+VPN_W-1:0] resp_vaddr_o,
  output logic [31:0]            stat_req_o,
  output logic [31:0]            stat_stall_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = IDX_W + VPN_W;
  localparam logic [3:0]       WAIT_INIT = 4'(LATENCY - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);

  logic [AW-1:0]     r_addr [DEPTH];
  logic [3:0]        r_wait [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              r_resp_valid;
  logic [LINE_W-1:0] r_resp_line;
  logic [AW-1:0]     r_resp_vaddr;

  logic              w_push;
  logic              w_fire;

  // Both ports use valid/ready: a transfer happens at a rising edge where valid and ready
  // are both high; ready depends only on registered state plus kill, never on valid.
  assign req_ready_o = (r_count < DEPTH_C) & ~req_kill_i;
  assign w_push      = req_valid_i & req_ready_o;
  assign w_fire      = ~req_kill_i & (r_count != '0) & (r_wait[r_rd_ptr] == 4'd0) &
                       (~r_resp_valid | resp_ready_i);
  assign mem_addr_o  = (r_count != '0) ? r_addr[r_rd_ptr] : '0;

  assign resp_valid_o = r_resp_valid;
  assign resp_line_o  = r_resp_line;
  assign resp_vaddr_o = r_resp_vaddr;

  always_ff @(posedge clk_i) begin
    if (w_push) r_addr[r_wr_ptr] <= {req_vpn_i, req_idx_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      for (int i = 0; i < DEPTH; i++) r_wait[i] <= 4'd0;
    end else if (req_kill_i) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && r_wait[i] != 4'd0) r_wait[i] <= r_wait[i] - 4'd1;
      end
      // Push and fire never touch the same slot: that needs count of 0 or DEPTH.
      if (w_push) begin
        r_wait[r_wr_ptr] <= WAIT_INIT;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_fire) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_line  <= '0;
      r_resp_vaddr <= '0;
    end else if (req_kill_i) begin
      r_resp_valid <= 1'b0;
    end else if (w_fire) begin
      r_resp_valid <= 1'b1;
      r_resp_line  <= mem_line_i;
      r_resp_vaddr <= mem_addr_o;
    end else if (resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

`ifdef SHIM_STATS_EN
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_stall;

  // Saturating counters; kill deliberately leaves them alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_req   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_push && r_stat_req != 32'hFFFF_FFFF) r_stat_req <= r_stat_req + 32'd1;
      if (r_resp_valid && !resp_ready_i && r_stat_stall != 32'hFFFF_FFFF)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_req_o   = r_stat_req;
  assign stat_stall_o = r_stat_stall;
`else
  assign stat_req_o   = 32'd0;
  assign stat_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_icache_mem_latency_shim.sv
// Directed bench for icache_mem_latency_shim: latency, fill/drain, backpressure, kill,
// asynchronous reset and pointer wrap, with a line-pattern memory model.
module tb_icache_mem_latency_shim;
  localparam int IDX_W  = 12;
  localparam int VPN_W  = 28;
  localparam int LINE_W = 128;
`ifdef SHIM_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [IDX_W-1:0]  req_idx = '0;
  logic [VPN_W-1:0]  req_vpn = '0;
  logic              req_kill = 1'b0;
  logic [39:0]       mem_addr;
  logic [LINE_W-1:0] mem_line;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [LINE_W-1:0] resp_line;
  logic [39:0]       resp_vaddr;
  logic [31:0]       stat_req;
  logic [31:0]       stat_stall;

  int n_checks = 0;
  int n_pass   = 0;
  logic [39:0] exp_q[$];

  icache_mem_latency_shim #(.DEPTH(4), .LATENCY(3), .IDX_W(IDX_W), .VPN_W(VPN_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_idx_i(req_idx), .req_vpn_i(req_vpn), .req_kill_i(req_kill),
    .mem_addr_o(mem_addr), .mem_line_i(mem_line), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .resp_line_o(resp_line), .resp_vaddr_o(resp_vaddr),
    .stat_req_o(stat_req), .stat_stall_o(stat_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] line_of(input logic [39:0] a);
    return {a, 8'hA5, ~a, a};
  endfunction

  function automatic logic [31:0] st(input int v);
    return STATS_ON ? 32'(v) : 32'd0;
  endfunction

  always_comb mem_line = line_of(mem_addr);

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [39:0] a);
    req_valid = v;
    req_vpn   = a[39:12];
    req_idx   = a[11:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] a_fill [5];
    logic [39:0] a_kill [4];
    logic [39:0] got;
    int j;
    int n_resp;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", req_ready, 1'b1);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_line", resp_line, '0);
    check("rst_vaddr", resp_vaddr, '0);
    check("rst_maddr", mem_addr, '0);
    check("rst_sreq", stat_req, 32'd0);
    check("rst_sstall", stat_stall, 32'd0);

    // Single request: valid exactly 3 edges after acceptance
    resp_ready = 1'b1;
    set_req(1'b1, 40'h00_0000_1010);
    tick();
    set_req(1'b0, '0);
    check("t1_maddr", mem_addr, 40'h00_0000_1010);
    check("t1_v1", resp_valid, 1'b0);
    tick();
    check("t1_v2", resp_valid, 1'b0);
    tick();
    check("t1_v3", resp_valid, 1'b1 ^ 1'b1);
    tick();
    check("t1_valid", resp_valid, 1'b1);
    check("t1_vaddr", resp_vaddr, 40'h00_0000_1010);
    check("t1_line", resp_line, line_of(40'h00_0000_1010));
    check("t1_maddr_empty", mem_addr, '0);
    tick();
    check("t1_clear", resp_valid, 1'b0);
    check("t1_sreq", stat_req, st(1));

    // Fill: first entry moves into the output register, then 4 more fill the queue
    resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) a_fill[k] = 40'h00_0000_2020 + 40'(k);
    for (int k = 0; k < 5; k++) begin
      check("fill_rdy", req_ready, 1'b1);
      set_req(1'b1, a_fill[k]);
      tick();
    end
    check("full_rdy", req_ready, 1'b0);
    set_req(1'b1, 40'h00_0000_2099);
    tick();
    check("full_rdy_hold", req_ready, 1'b0);
    set_req(1'b0, '0);
    check("fill_sreq", stat_req, st(6));
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_valid", resp_valid, 1'b1);
      check("drain_vaddr", resp_vaddr, a_fill[k]);
      check("drain_line", resp_line, line_of(a_fill[k]));
      tick();
    end
    check("drain_done", resp_valid, 1'b0);
    check("drain_rdy", req_ready, 1'b1);

    // Kill with 3 queued and one response held
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) a_kill[k] = 40'h00_0000_3030 + 40'(k);
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, a_kill[k]);
      tick();
    end
    set_req(1'b0, '0);
    check("kill_pre_valid", resp_valid, 1'b1);
    check("kill_pre_vaddr", resp_vaddr, a_kill[0]);
    req_kill = 1'b1;
    #1;
    check("kill_rdy_low", req_ready, 1'b0);
    tick();
    req_kill = 1'b0;
    #1;
    check("kill_valid", resp_valid, 1'b0);
    check("kill_rdy", req_ready, 1'b1);
    check("kill_maddr", mem_addr, '0);
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("kill_no_stale", resp_valid, 1'b0);
    end
    set_req(1'b1, 40'h00_0000_4044);
    tick();
    set_req(1'b0, '0);
    tick(); tick();
    check("kill_new_early", resp_valid, 1'b0);
    tick();
    check("kill_new_valid", resp_valid, 1'b1);
    check("kill_new_vaddr", resp_vaddr, 40'h00_0000_4044);
    check("kill_sreq", stat_req, st(11));
    tick();
    check("kill_new_clear", resp_valid, 1'b0);

    // Asynchronous reset with 2 entries queued
    set_req(1'b1, 40'h00_0000_5050);
    tick();
    set_req(1'b1, 40'h00_0000_5051);
    tick();
    set_req(1'b0, '0);
    check("mid_maddr", mem_addr, 40'h00_0000_5050);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", req_ready, 1'b1);
    check("arst_valid", resp_valid, 1'b0);
    check("arst_line", resp_line, '0);
    check("arst_vaddr", resp_vaddr, '0);
    check("arst_maddr", mem_addr, '0);
    check("arst_sreq", stat_req, 32'd0);
    tick();
    rst = 1'b0;
    check("post_rst_sreq", stat_req, 32'd0);
    check("post_rst_sstall", stat_stall, 32'd0);
    set_req(1'b1, 40'h00_0000_6060);
    tick();
    set_req(1'b0, '0);
    tick(); tick();
    check("post_rst_early", resp_valid, 1'b0);
    tick();
    check("post_rst_valid", resp_valid, 1'b1);
    check("post_rst_vaddr", resp_vaddr, 40'h00_0000_6060);
    tick();

    // Backpressure hold for 5 cycles
    resp_ready = 1'b0;
    set_req(1'b1, 40'h00_0000_7077);
    tick();
    set_req(1'b0, '0);
    tick(); tick(); tick();
    check("bp_valid", resp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", resp_valid, 1'b1);
      check("bp_hold_vaddr", resp_vaddr, 40'h00_0000_7077);
      check("bp_hold_line", resp_line, line_of(40'h00_0000_7077));
    end
    check("bp_stall", stat_stall, st(5));
    resp_ready = 1'b1;
    tick();
    check("bp_release", resp_valid, 1'b0);
    check("bp_stall_after", stat_stall, st(5));
    check("bp_sreq", stat_req, st(2));

    // Pointer wrap: 10 back-to-back requests through the scoreboard
    j = 0;
    n_resp = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (j < 10) begin
        check("wrap_rdy", req_ready, 1'b1);
        set_req(1'b1, 40'h00_0000_0100 + 40'(j));
        exp_q.push_back(40'h00_0000_0100 + 40'(j));
        j++;
      end else begin
        set_req(1'b0, '0);
      end
      tick();
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          check("wrap_extra", resp_vaddr, '0 - 40'd1);
        end else begin
          got = exp_q.pop_front();
          check("wrap_vaddr", resp_vaddr, got);
          check("wrap_line", resp_line, line_of(got));
        end
      end
    end
    check("wrap_count", n_resp, 10);
    check("wrap_left", exp_q.size(), 0);
    check("wrap_sreq", stat_req, st(12));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
